// File: rtl/clock12_ctrl.sv
// 12-hour clock controller: sec/min/hour chain, debounced mode/inc buttons, run/set FSM.
// Optional PM flag register enabled by defining CLK12_PM_FLAG_EN.
module clock12_ctrl #(
  parameter int unsigned DEBOUNCE_CYC = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [3:0] hour,
  output logic       pm,
  output logic [1:0] mode,
  output logic       blink
);

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StSetHr  = 2'd1,
    StSetMin = 2'd2,
    StBad    = 2'd3
  } state_e;

  localparam logic [7:0] DbLast = 8'(DEBOUNCE_CYC - 1);

  // Bit 0 is the mode button, bit 1 the increment button.
  logic [1:0] w_raw;
  logic [1:0] r_sync1;
  logic [1:0] r_sync2;
  logic [1:0] r_db;
  logic [1:0] r_ev;
  logic [7:0] r_cnt [2];

  assign w_raw = {inc_btn, mode_btn};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_db     <= '0;
      r_ev     <= '0;
      r_cnt[0] <= '0;
      r_cnt[1] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 2; i++) begin
        r_ev[i] <= 1'b0;
        if (r_sync2[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DbLast) begin
          r_cnt[i] <= '0;
          r_db[i]  <= r_sync2[i];
          // Event is registered alongside the accepted level; only rises count.
          r_ev[i]  <= r_sync2[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + 8'd1;
        end
      end
    end
  end

  state_e     r_state;
  logic [5:0] r_sec;
  logic [5:0] r_min;
  logic [3:0] r_hour;
  logic       r_blink;
  logic       w_mode_ev;
  logic       w_inc_ev;

  assign w_mode_ev = r_ev[0];
  assign w_inc_ev  = r_ev[1];

  // A mode event pre-empts tick and inc in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StRun;
      r_sec   <= '0;
      r_min   <= '0;
      r_hour  <= '0;
      r_blink <= 1'b0;
    end else begin
      case (r_state)
        StRun: begin
          if (w_mode_ev) begin
            r_state <= StSetHr;
            r_sec   <= '0;
            r_blink <= 1'b0;
          end else if (tick) begin
            if (r_sec == 6'd59) begin
              r_sec <= '0;
              if (r_min == 6'd59) begin
                r_min  <= '0;
                r_hour <= (r_hour == 4'd11) ? 4'd0 : r_hour + 4'd1;
              end else begin
                r_min <= r_min + 6'd1;
              end
            end else begin
              r_sec <= r_sec + 6'd1;
            end
          end
        end
        StSetHr: begin
          if (w_mode_ev) begin
            r_state <= StSetMin;
            r_blink <= 1'b0;
          end else begin
            if (w_inc_ev) r_hour <= (r_hour == 4'd11) ? 4'd0 : r_hour + 4'd1;
            if (tick) r_blink <= ~r_blink;
          end
        end
        StSetMin: begin
          if (w_mode_ev) begin
            r_state <= StRun;
            r_blink <= 1'b0;
          end else begin
            if (w_inc_ev) r_min <= (r_min == 6'd59) ? 6'd0 : r_min + 6'd1;
            if (tick) r_blink <= ~r_blink;
          end
        end
        default: begin
          r_state <= StRun;
          r_blink <= 1'b0;
        end
      endcase
    end
  end

`ifdef CLK12_PM_FLAG_EN
  logic w_hr_wrap;
  logic r_pm;

  assign w_hr_wrap = (r_hour == 4'd11) && !w_mode_ev &&
                     (((r_state == StRun) && tick && (r_sec == 6'd59) && (r_min == 6'd59)) ||
                      ((r_state == StSetHr) && w_inc_ev));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pm <= 1'b0;
    end else if (w_hr_wrap) begin
      r_pm <= ~r_pm;
    end
  end

  assign pm = r_pm;
`else
  assign pm = 1'b0;
`endif

  assign sec   = r_sec;
  assign min   = r_min;
  assign hour  = r_hour;
  assign mode  = r_state;
  assign blink = r_blink;

endmodule
